// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one memory port between the CPU fetch and data ports.
// Each pipeline step issues at most one fetch and one data access, captures
// the results, and raises both valids together once the step is complete.
module cpu_mem_arbiter #(
    parameter bit          DATA_FIRST = 1'b1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_hold,
    input  logic [31:0] i_addr_i,
    output logic [31:0] o_data_i,
    output logic        o_valid_i,
    input  logic [31:0] i_addr_d,
    input  logic [31:0] i_data_wr_d,
    input  logic [3:0]  i_wr_d,
    input  logic        i_rd_d,
    output logic [31:0] o_data_rd_d,
    output logic        o_valid_d,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_we,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_bus_err
);

    // Counter runs 0..TIMEOUT-1 while a request waits; the last value forces completion.
    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DATA,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;
    logic               valid_i_q, valid_i_d;
    logic               valid_d_q, valid_d_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_we_q, mem_we_d;
    logic [31:0]        data_i_q, data_i_d;
    logic [31:0]        data_rd_q, data_rd_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               dreq;
    logic               ack_seen;
    logic               timed_out;
    logic               acc_done;
    logic [31:0]        cap_data;
    logic               go_fetch, go_data, go_done;

    // An ack only counts while a request is actually outstanding.
    assign dreq      = i_rd_d | (|i_wr_d);
    assign ack_seen  = mem_req_q & i_mem_ack;
    assign timed_out = (TIMEOUT != 0) && mem_req_q && !i_mem_ack && (cnt_q == CNT_LAST);
    assign acc_done  = ack_seen | timed_out;
    assign cap_data  = ack_seen ? i_mem_rdata : 32'h0;

    // Next-state and next-output logic for the step sequencer.
    always_comb begin
        // NOTE: every _d starts from its held value so no path can infer a latch.
        state_d     = state_q;
        i_done_d    = i_done_q;
        d_done_d    = d_done_q;
        valid_i_d   = valid_i_q;
        valid_d_d   = valid_d_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        data_i_d    = data_i_q;
        data_rd_d   = data_rd_q;
        cnt_d       = cnt_q;
        bus_err_d   = timed_out;
        go_fetch    = 1'b0;
        go_data     = 1'b0;
        go_done     = 1'b0;

        if (mem_req_q && !acc_done && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // A step without a data access counts its data side as done at once.
                d_done_d = !dreq;
                if (dreq && DATA_FIRST) go_data  = 1'b1;
                else                    go_fetch = 1'b1;
            end
            ST_FETCH: begin
                if (acc_done) begin
                    data_i_d = cap_data;
                    i_done_d = 1'b1;
                    if (!d_done_q) go_data = 1'b1;
                    else           go_done = 1'b1;
                end
            end
            ST_DATA: begin
                if (acc_done) begin
                    if (mem_we_q == 4'b0000) data_rd_d = cap_data;
                    d_done_d = 1'b1;
                    if (!i_done_q) go_fetch = 1'b1;
                    else           go_done  = 1'b1;
                end
            end
            ST_DONE: begin
                if (!i_hold) begin
                    state_d   = ST_IDLE;
                    i_done_d  = 1'b0;
                    d_done_d  = 1'b0;
                    valid_i_d = 1'b0;
                    valid_d_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Entering an access loads the registered memory-side outputs for it.
        if (go_fetch) begin
            state_d    = ST_FETCH;
            mem_req_d  = 1'b1;
            mem_addr_d = i_addr_i;
            mem_we_d   = 4'b0000;
            cnt_d      = '0;
        end
        if (go_data) begin
            state_d     = ST_DATA;
            mem_req_d   = 1'b1;
            mem_addr_d  = i_addr_d;
            mem_wdata_d = i_data_wr_d;
            mem_we_d    = i_wr_d;
            cnt_d       = '0;
        end
        // Valids are exposed only in DONE so the CPU sees both rise together.
        if (go_done) begin
            state_d   = ST_DONE;
            mem_req_d = 1'b0;
            valid_i_d = 1'b1;
            valid_d_d = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments make every flop update from pre-edge values.
        if (i_rst) begin
            state_q     <= ST_IDLE;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            valid_i_q   <= 1'b0;
            valid_d_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 4'b0000;
            data_i_q    <= 32'h0;
            data_rd_q   <= 32'h0;
            bus_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            valid_i_q   <= valid_i_d;
            valid_d_q   <= valid_d_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            data_i_q    <= data_i_d;
            data_rd_q   <= data_rd_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_data_i    = data_i_q;
    assign o_valid_i   = valid_i_q;
    assign o_data_rd_d = data_rd_q;
    assign o_valid_d   = valid_d_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_req   = mem_req_q;
    assign o_bus_err   = bus_err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed and random pipeline steps against a step-level
// reference model (access order, wait/timeout arithmetic, expected results).
module tb_cpu_mem_arbiter;

    localparam int TO = 4;
    localparam bit DF = 1'b1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_hold = 1'b0;
    logic [31:0] i_addr_i = '0;
    logic [31:0] o_data_i;
    logic        o_valid_i;
    logic [31:0] i_addr_d = '0;
    logic [31:0] i_data_wr_d = '0;
    logic [3:0]  i_wr_d = '0;
    logic        i_rd_d = 1'b0;
    logic [31:0] o_data_rd_d;
    logic        o_valid_d;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_we;
    logic        o_mem_req;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_bus_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_di = '0;
    logic [31:0] exp_rd = '0;

    cpu_mem_arbiter #(.DATA_FIRST(DF), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_hold(i_hold),
        .i_addr_i(i_addr_i), .o_data_i(o_data_i), .o_valid_i(o_valid_i),
        .i_addr_d(i_addr_d), .i_data_wr_d(i_data_wr_d), .i_wr_d(i_wr_d),
        .i_rd_d(i_rd_d), .o_data_rd_d(o_data_rd_d), .o_valid_d(o_valid_d),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
        .o_mem_req(o_mem_req), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_bus_err(o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one pipeline step. Entered at the falling edge of the step's IDLE
    // cycle, returns at the falling edge of the next step's IDLE cycle.
    // A wait of TO or more means memory never acks that access.
    task automatic do_step(input logic [31:0] ai, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [3:0] we,
                           input logic rd, input int wait_i, input int wait_d,
                           input logic [31:0] rdat_i, input logic [31:0] rdat_d,
                           input int hold, input bit junk);
        bit          a_fetch [2];
        logic [31:0] a_addr [2];
        logic [3:0]  a_we [2];
        logic [31:0] a_rdat [2];
        int          a_wait [2];
        int          n;
        int          idx = 0;
        int          acc_cyc = 0;
        int          done_cyc = 0;
        bit          err_next = 1'b0;
        bit          in_done;
        bit          dreq;
        logic [31:0] new_di;
        logic [31:0] new_rd;

        dreq = rd | (|we);
        a_fetch[0] = 1'b1; a_addr[0] = ai; a_we[0] = 4'b0; a_rdat[0] = rdat_i; a_wait[0] = wait_i;
        a_fetch[1] = 1'b0; a_addr[1] = ad; a_we[1] = we;   a_rdat[1] = rdat_d; a_wait[1] = wait_d;
        n = dreq ? 2 : 1;
        if (dreq && DF) begin
            a_fetch[0] = 1'b0; a_addr[0] = ad; a_we[0] = we;   a_rdat[0] = rdat_d; a_wait[0] = wait_d;
            a_fetch[1] = 1'b1; a_addr[1] = ai; a_we[1] = 4'b0; a_rdat[1] = rdat_i; a_wait[1] = wait_i;
        end

        new_di = exp_di;
        new_rd = exp_rd;
        for (int k = 0; k < n; k++) begin
            if (a_fetch[k])              new_di = (a_wait[k] >= TO) ? 32'h0 : a_rdat[k];
            else if (a_we[k] == 4'b0000) new_rd = (a_wait[k] >= TO) ? 32'h0 : a_rdat[k];
        end

        // NOTE: inputs are driven with blocking assignments on the falling edge, away from sampling.
        i_addr_i = ai; i_addr_d = ad; i_data_wr_d = wd; i_wr_d = we; i_rd_d = rd; i_hold = 1'b0;

        for (int cyc = 0; cyc < 64; cyc++) begin
            if (cyc > 0) @(negedge i_clk);
            in_done = (cyc > 0) && (idx == n);
            check("mem_req",  32'(o_mem_req), 32'(!in_done && cyc > 0));
            check("valid_i",  32'(o_valid_i), 32'(in_done));
            check("valid_d",  32'(o_valid_d), 32'(in_done));
            check("bus_err",  32'(o_bus_err), 32'(err_next));
            err_next = 1'b0;
            i_mem_ack = 1'b0;
            i_mem_rdata = $urandom();
            if (cyc == 0) begin
                check("idle_data_i",  o_data_i,    exp_di);
                check("idle_data_rd", o_data_rd_d, exp_rd);
            end
            if (!in_done && cyc > 0) begin
                check("mem_addr", o_mem_addr, a_addr[idx]);
                check("mem_we",   32'(o_mem_we), 32'(a_we[idx]));
                if (!a_fetch[idx]) check("mem_wdata", o_mem_wdata, wd);
                if (acc_cyc == a_wait[idx] && a_wait[idx] < TO) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = a_rdat[idx];
                    idx++;
                    acc_cyc = 0;
                end else if (acc_cyc + 1 == TO) begin
                    err_next = 1'b1;
                    idx++;
                    acc_cyc = 0;
                end else begin
                    acc_cyc++;
                end
            end else if ((junk && cyc == 0) || ($urandom_range(0, 3) == 0)) begin
                // Stray ack while no request is outstanding must be ignored.
                i_mem_ack = 1'b1;
            end
            if (in_done) begin
                check("data_i",  o_data_i,    new_di);
                check("data_rd", o_data_rd_d, new_rd);
                if (done_cyc < hold) begin
                    i_hold = 1'b1;
                    done_cyc++;
                end else begin
                    i_hold = 1'b0;
                    break;
                end
            end
        end
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        exp_di = new_di;
        exp_rd = new_rd;
    endtask

    initial begin
        logic [31:0] ai;
        logic [31:0] ad;
        logic [3:0]  we;
        int          kind;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst_req",     32'(o_mem_req), 32'h0);
        check("rst_we",      32'(o_mem_we),  32'h0);
        check("rst_addr",    o_mem_addr,     32'h0);
        check("rst_wdata",   o_mem_wdata,    32'h0);
        check("rst_data_i",  o_data_i,       32'h0);
        check("rst_data_rd", o_data_rd_d,    32'h0);
        check("rst_valid_i", 32'(o_valid_i), 32'h0);
        check("rst_valid_d", 32'(o_valid_d), 32'h0);
        check("rst_bus_err", 32'(o_bus_err), 32'h0);

        // Fetch-only steps with zero-wait memory.
        do_step(32'h0, 32'h0, 32'h0, 4'b0, 1'b0, 0, 0, 32'h0000_0013, 32'h0, 0, 1'b0);
        do_step(32'h4, 32'h0, 32'h0, 4'b0, 1'b0, 0, 0, 32'h1234_5678, 32'h0, 0, 1'b0);
        // Load, data first, two wait cycles.
        do_step(32'h8, 32'h100, 32'h0, 4'b0, 1'b1, 0, 2, 32'h0000_0093, 32'hDEAD_BEEF, 0, 1'b0);
        // Store: byte enables and write data held until ack, load data untouched.
        do_step(32'hC, 32'h200, 32'h0000_ABCD, 4'b0011, 1'b0, 1, 3, 32'h0000_0113, 32'h5555_5555, 0, 1'b0);
        // CPU hold in DONE for 5 cycles.
        do_step(32'h10, 32'h0, 32'h0, 4'b0, 1'b0, 1, 0, 32'hCAFE_F00D, 32'h0, 5, 1'b0);
        // Fetch never acked: timeout, zero data, one bus error pulse.
        do_step(32'h14, 32'h0, 32'h0, 4'b0, 1'b0, 100, 0, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
        // Load never acked, fetch acks on the last legal cycle.
        do_step(32'h18, 32'h300, 32'h0, 4'b0, 1'b1, TO - 1, 100, 32'h0BAD_F00D, 32'h7777_7777, 1, 1'b0);

        // Reset during a data wait; ack with reset and a late ack are both ignored.
        i_addr_i = 32'h40; i_addr_d = 32'h300; i_data_wr_d = 32'h0; i_wr_d = 4'b0; i_rd_d = 1'b1;
        @(negedge i_clk);
        check("pre_rst_req",  32'(o_mem_req), 32'h1);
        check("pre_rst_addr", o_mem_addr,     32'h300);
        @(negedge i_clk);
        i_rst = 1'b1;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'hBADB_AD01;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_mem_ack = 1'b0;
        exp_di = 32'h0;
        exp_rd = 32'h0;
        do_step(32'h0, 32'h0, 32'h0, 4'b0, 1'b0, 0, 0, 32'h0000_0013, 32'h0, 0, 1'b1);

        // Random steps.
        for (int s = 0; s < 40; s++) begin
            ai = $urandom() & 32'hFFFF_FFFC;
            ad = $urandom();
            kind = $urandom_range(0, 2);
            we = (kind == 2) ? 4'($urandom_range(1, 15)) : 4'b0000;
            do_step(ai, ad, $urandom(), we, kind == 1,
                    $urandom_range(0, TO + 1), $urandom_range(0, TO + 1),
                    $urandom(), $urandom(), $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one external memory port between the CPU instruction-fetch port and its data port.
- Sequences at most one fetch and one data access per CPU pipeline step. Captures the results and drives the CPU's i_valid_i / i_valid_d stall inputs, so the pipeline advances only when both accesses of the step are complete.
- Sits between the cpu top level and the single-port memory / bus fabric.

Parameters:
- DATA_FIRST, 1, when 1 the data access of a step is issued before the fetch; when 0 the fetch is issued first.
- TIMEOUT, 255, maximum cycles o_mem_req may wait for i_mem_ack before the access is force-completed; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_hold  in  1  CPU internal stall (ALU busy); the CPU does not advance while high.
- i_addr_i  in  32  CPU fetch address.
- o_data_i  out  32  fetched instruction to CPU.
- o_valid_i  out  1  fetch complete for current step.
- i_addr_d  in  32  CPU data address.
- i_data_wr_d  in  32  CPU store data.
- i_wr_d  in  4  CPU byte write enables.
- i_rd_d  in  1  CPU load request.
- o_data_rd_d  out  32  load data to CPU.
- o_valid_d  out  1  data access complete, or no data access this step.
- o_mem_addr  out  32  memory address.
- o_mem_wdata  out  32  memory write data.
- o_mem_we  out  4  memory byte enables; 0 means read.
- o_mem_req  out  1  memory request.
- i_mem_ack  in  1  memory completion, one-cycle pulse.
- i_mem_rdata  in  32  memory read data, valid with i_mem_ack.
- o_bus_err  out  1  one-cycle pulse when an access times out.

Behaviour:
- Data access needed (dreq) = i_rd_d | (|i_wr_d), sampled in IDLE.
- State machine states: IDLE, FETCH, DATA, DONE. All memory-side outputs are registered.
- IDLE: i_done and d_done are clear.
  - If dreq and DATA_FIRST=1, go to DATA; otherwise go to FETCH.
  - d_done is set on entry when dreq=0.
- FETCH: drives o_mem_req=1, o_mem_addr=i_addr_i, o_mem_we=0.
  - On i_mem_ack: o_data_i <= i_mem_rdata and i_done set.
  - Next state is DATA if dreq and data is still pending, else DONE.
- DATA: drives o_mem_req=1, o_mem_addr=i_addr_d, o_mem_wdata=i_data_wr_d, o_mem_we=i_wr_d.
  - On i_mem_ack: if the access is a load, o_data_rd_d <= i_mem_rdata; d_done is set.
  - Next state is FETCH if fetch is still pending, else DONE.
- Request rules:
  - o_mem_req stays high with stable addr, wdata and we until ack.
  - Ack is legal in any cycle req is high, including the first.
  - Req drops in the cycle after ack when going to DONE. Going directly FETCH<->DATA keeps req high with the new address.
- o_valid_i = i_done, o_valid_d = d_done. Both are registered and held in DONE.
- DONE: the CPU advances at the edge where o_valid_i & o_valid_d & !i_hold. At that edge go to IDLE and clear both done flags. While i_hold=1, stay in DONE with captured data held.
- Minimum step time with a zero-wait memory:
  - Fetch only: 3 cycles (IDLE, FETCH, DONE).
  - Fetch + data: 4 cycles.
- Timeout:
  - A per-access counter resets on each new request.
  - If it reaches TIMEOUT without ack: complete the access with read data 32'h0, pulse o_bus_err for one cycle, and continue as if acked.
- Ack handling: an ack while o_mem_req=0 is ignored. Read data is captured only on ack (or on timeout, as zero).
- Reset values: state IDLE, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_data_i=0, o_data_rd_d=0, o_valid_i=0, o_valid_d=0, o_bus_err=0, timeout counter=0.
- Reset mid-access:
  - Abandon the request immediately; req=0 in the cycle after the reset edge.
  - An ack arriving later is ignored.
  - A write may or may not have been committed by memory; no retry is made.
- An ack from memory in the same cycle as reset is ignored.

Test Plan:
1. Reset, then fetch-only steps with zero-wait memory, instruction at 0x0 = 0x00000013 → req at cycle 1, o_valid_i/o_valid_d high at cycle 2, o_data_i=0x00000013; the next fetch of 0x4 starts 3 cycles later.
2. Load step, DATA_FIRST=1, i_addr_d=0x100, memory returns 0xDEADBEEF after 2 wait cycles, fetch has 0 waits → data request precedes fetch; o_data_rd_d=0xDEADBEEF; both valids rise together in the same cycle.
3. Store with i_wr_d=4'b0011, data 0x0000ABCD to 0x200 → o_mem_we=4'b0011, o_mem_wdata=0x0000ABCD held until ack; o_data_rd_d unchanged.
4. i_hold high for 5 cycles in DONE → valids and o_data_i stay stable; no new o_mem_req until 1 cycle after i_hold falls.
5. TIMEOUT=4, memory never acks a fetch → o_bus_err pulses once after 4 req cycles; o_data_i=0; the step completes.
6. Assert i_rst during the DATA wait, then ack 2 cycles later → o_mem_req=0 after reset, the late ack is ignored, and the first post-reset fetch behaves as in scenario 1.
